// File: rtl/traffic_light_controller_pkg.sv
// Shared types and light encodings for the two-way intersection sequencer.
package traffic_pkg;

    typedef enum logic [2:0] {
        NS_GREEN  = 3'd0,
        NS_YELLOW = 3'd1,
        ALL_RED   = 3'd2,
        WALK      = 3'd3,
        EW_GREEN  = 3'd4,
        EW_YELLOW = 3'd5
    } state_t;

    localparam logic [2:0] LIGHT_RED    = 3'b100;
    localparam logic [2:0] LIGHT_YELLOW = 3'b010;
    localparam logic [2:0] LIGHT_GREEN  = 3'b001;

    localparam logic DIR_NS = 1'b0;
    localparam logic DIR_EW = 1'b1;

    function automatic logic [2:0] nsLightOf(input state_t s);
        case (s)
            NS_GREEN:  return LIGHT_GREEN;
            NS_YELLOW: return LIGHT_YELLOW;
            default:   return LIGHT_RED;
        endcase
    endfunction

    function automatic logic [2:0] ewLightOf(input state_t s);
        case (s)
            EW_GREEN:  return LIGHT_GREEN;
            EW_YELLOW: return LIGHT_YELLOW;
            default:   return LIGHT_RED;
        endcase
    endfunction

endpackage

// File: rtl/traffic_light_controller_tick_edge_detect.sv
// Brings the divider's slow square wave into the clk domain and turns each
// rising edge into a single-cycle tick.
module tick_edge_detect (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic tick
);

    logic s1Q;
    logic s2Q;
    logic prevQ;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1Q   <= 1'b0;
            s2Q   <= 1'b0;
            prevQ <= 1'b0;
        end else begin
            s1Q   <= din;
            s2Q   <= s1Q;
            prevQ <= s2Q;
        end
    end

    assign tick = s2Q & ~prevQ;

endmodule

// File: rtl/traffic_light_controller.sv
// NS/EW intersection sequencer with a pedestrian walk phase; dwell times are
// counted in ticks derived from the slow divider clock.
module traffic_light_controller
    import traffic_pkg::*;
#(
    parameter int unsigned GREEN_T  = 10,
    parameter int unsigned YELLOW_T = 3,
    parameter int unsigned ALLRED_T = 1,
    parameter int unsigned WALK_T   = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       slow_clk,
    input  logic       ped_req,
    output logic [2:0] ns_light,
    output logic [2:0] ew_light,
    output logic       walk,
    output logic [7:0] remaining
);

    localparam logic [7:0] GREEN_LOAD  = 8'(GREEN_T - 1);
    localparam logic [7:0] YELLOW_LOAD = 8'(YELLOW_T - 1);
    localparam logic [7:0] ALLRED_LOAD = 8'(ALLRED_T - 1);
    localparam logic [7:0] WALK_LOAD   = 8'(WALK_T - 1);

    logic       tick;
    state_t     stateQ, stateD;
    logic [7:0] timerQ, timerD;
    logic       pedPendingQ, pedPendingD;
    logic       nextDirQ, nextDirD;
    logic [2:0] nsLightQ;
    logic [2:0] ewLightQ;
    logic       walkQ;

    tick_edge_detect uTick (
        .clk  (clk),
        .rst  (rst),
        .din  (slow_clk),
        .tick (tick)
    );

    function automatic logic [7:0] loadFor(input state_t s);
        case (s)
            NS_YELLOW, EW_YELLOW: return YELLOW_LOAD;
            ALL_RED:              return ALLRED_LOAD;
            WALK:                 return WALK_LOAD;
            default:              return GREEN_LOAD;
        endcase
    endfunction

    always_comb begin
        stateD      = stateQ;
        timerD      = timerQ;
        nextDirD    = nextDirQ;
        pedPendingD = pedPendingQ;

        if (ped_req && stateQ != WALK) begin
            pedPendingD = 1'b1;
        end

        if (tick) begin
            if (timerQ != 8'd0) begin
                timerD = timerQ - 8'd1;
            end else begin
                case (stateQ)
                    NS_GREEN:  stateD = NS_YELLOW;
                    NS_YELLOW: stateD = ALL_RED;
                    ALL_RED: begin
                        // A press landing on the exit tick itself still earns the walk.
                        if (pedPendingQ || ped_req) begin
                            stateD = WALK;
                        end else begin
                            stateD = (nextDirQ == DIR_EW) ? EW_GREEN : NS_GREEN;
                        end
                    end
                    WALK:      stateD = (nextDirQ == DIR_EW) ? EW_GREEN : NS_GREEN;
                    EW_GREEN:  stateD = EW_YELLOW;
                    EW_YELLOW: stateD = ALL_RED;
                    default:   stateD = NS_GREEN;
                endcase

                timerD = loadFor(stateD);

                if (stateD == WALK) begin
                    pedPendingD = 1'b0;
                end
                if (stateD == NS_GREEN) begin
                    nextDirD = DIR_EW;
                end
                if (stateD == EW_GREEN) begin
                    nextDirD = DIR_NS;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stateQ      <= NS_GREEN;
            timerQ      <= GREEN_LOAD;
            pedPendingQ <= 1'b0;
            nextDirQ    <= DIR_EW;
            nsLightQ    <= LIGHT_GREEN;
            ewLightQ    <= LIGHT_RED;
            walkQ       <= 1'b0;
        end else begin
            stateQ      <= stateD;
            timerQ      <= timerD;
            pedPendingQ <= pedPendingD;
            nextDirQ    <= nextDirD;
            nsLightQ    <= nsLightOf(stateD);
            ewLightQ    <= ewLightOf(stateD);
            walkQ       <= (stateD == WALK);
        end
    end

    assign ns_light  = nsLightQ;
    assign ew_light  = ewLightQ;
    assign walk      = walkQ;
    assign remaining = timerQ;

endmodule
